// File: rtl/ctx_seq_pkg.sv
// rtl/ctx_seq_pkg.sv - shared constants for the register-file context sequencer
//
// Purpose: default sizing and FSM state encoding used by regfile_ctx_sequencer.
// Ports:   none (package).
// Config:  CTX_MASK_EN is consumed by regfile_ctx_sequencer, not by this package.

package ctx_seq_pkg;

   localparam int NUM_REGS_DEF = 16;
   localparam int DATA_W_DEF   = 8;
   localparam int ADDR_W_DEF   = 16;
   localparam int REG_IDX_W    = $clog2(NUM_REGS_DEF);

   localparam int ST_W = 3;

   localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [ST_W-1:0] ST_SAVE_RD = 3'd1;
   localparam logic [ST_W-1:0] ST_SAVE_WR = 3'd2;
   localparam logic [ST_W-1:0] ST_REST_RD = 3'd3;
   localparam logic [ST_W-1:0] ST_REST_WB = 3'd4;
   localparam logic [ST_W-1:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/regfile_ctx_sequencer.sv
// rtl/regfile_ctx_sequencer.sv - saves/restores the register file to/from a memory stack
//
// Purpose: on interrupt entry pushes r[NUM_REGS-1]..r0 below sp_in; on return pops
//          r0..r[NUM_REGS-1] from sp_in upwards. Owns the regfile and memory ports while
//          busy and stalls the core.
// Config:  CTX_MASK_EN adds reg_mask; only registers with a set mask bit are transferred.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   save_req, rest_req    start save / restore, sampled only in IDLE (save wins)
//   sp_in                 stack pointer latched on acceptance
//   reg_mask              (CTX_MASK_EN only) per-register transfer enable
//   busy, cpu_stall       high from the cycle after acceptance through DONE
//   done                  one-cycle pulse in DONE
//   sp_out                final stack pointer, held from DONE until the next DONE
//   rf_sel/rf_dout        regfile read select and data
//   rf_din/rf_we          regfile write data and enable
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack   data-memory handshake

module regfile_ctx_sequencer
   import ctx_seq_pkg::*;
#(
   parameter  int NUM_REGS = NUM_REGS_DEF,
   parameter  int DATA_W   = DATA_W_DEF,
   parameter  int ADDR_W   = ADDR_W_DEF,
   localparam int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                save_req,
   input  logic                rest_req,
   input  logic [ADDR_W-1:0]   sp_in,
`ifdef CTX_MASK_EN
   input  logic [NUM_REGS-1:0] reg_mask,
`endif
   output logic                busy,
   output logic                cpu_stall,
   output logic                done,
   output logic [ADDR_W-1:0]   sp_out,
   output logic [IDX_W-1:0]    rf_sel,
   input  logic [DATA_W-1:0]   rf_dout,
   output logic [DATA_W-1:0]   rf_din,
   output logic                rf_we,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   logic [ST_W-1:0]   state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] sp_out_q, sp_out_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              xfer;

`ifdef CTX_MASK_EN
   logic [NUM_REGS-1:0] mask_q, mask_d;
   assign xfer = mask_q[idx_q];
`else
   assign xfer = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      sp_out_d = sp_out_q;
      data_d   = data_q;
`ifdef CTX_MASK_EN
      mask_d   = mask_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (save_req || rest_req) begin
               ptr_d = sp_in;
`ifdef CTX_MASK_EN
               mask_d = reg_mask;
`endif
               if (save_req) begin
                  state_d = ST_SAVE_RD;
                  idx_d   = LAST_IDX;
               end else begin
                  state_d = ST_REST_RD;
                  idx_d   = '0;
               end
            end
         end
         ST_SAVE_RD: begin
            if (xfer) begin
               // Pre-decrement: the stack grows down, so r15 lands at sp-1.
               data_d  = rf_dout;
               ptr_d   = ptr_q - 1'b1;
               state_d = ST_SAVE_WR;
            end else if (idx_q == '0) begin
               state_d  = ST_DONE;
               sp_out_d = ptr_q;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         ST_SAVE_WR: begin
            if (mem_ack) begin
               if (idx_q == '0) begin
                  state_d  = ST_DONE;
                  sp_out_d = ptr_q;
               end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = ST_SAVE_RD;
               end
            end
         end
         ST_REST_RD: begin
            if (!xfer) begin
               if (idx_q == LAST_IDX) begin
                  state_d  = ST_DONE;
                  sp_out_d = ptr_q;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else if (mem_ack) begin
               data_d  = mem_rdata;
               ptr_d   = ptr_q + 1'b1;
               state_d = ST_REST_WB;
            end
         end
         ST_REST_WB: begin
            if (idx_q == LAST_IDX) begin
               state_d  = ST_DONE;
               sp_out_d = ptr_q;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_REST_RD;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         ptr_q    <= '0;
         sp_out_q <= '0;
         data_q   <= '0;
`ifdef CTX_MASK_EN
         mask_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ptr_q    <= ptr_d;
         sp_out_q <= sp_out_d;
         data_q   <= data_d;
`ifdef CTX_MASK_EN
         mask_q   <= mask_d;
`endif
      end
   end

   // Outputs decode straight from registered state so an asynchronous reset
   // clears them in the same cycle.
   always_comb begin
      busy      = (state_q != ST_IDLE);
      cpu_stall = busy;
      done      = (state_q == ST_DONE);
      sp_out    = sp_out_q;
      rf_sel    = '0;
      rf_din    = '0;
      rf_we     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         ST_SAVE_RD: rf_sel = idx_q;
         ST_SAVE_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ptr_q;
            mem_wdata = data_q;
         end
         ST_REST_RD: begin
            mem_req  = xfer;
            mem_addr = xfer ? ptr_q : '0;
         end
         ST_REST_WB: begin
            rf_sel = idx_q;
            rf_din = data_q;
            rf_we  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_regfile_ctx_sequencer.sv
// tb/tb_regfile_ctx_sequencer.sv - self-checking bench for regfile_ctx_sequencer

module tb_regfile_ctx_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        save_req = 1'b0;
   logic        rest_req = 1'b0;
   logic [15:0] sp_in = '0;
   logic [15:0] reg_mask = 16'hFFFF;
   logic        busy, cpu_stall, done, rf_we, mem_req, mem_we, mem_ack;
   logic [15:0] sp_out, mem_addr;
   logic [3:0]  rf_sel;
   logic [7:0]  rf_dout, rf_din, mem_wdata, mem_rdata;

   logic [7:0]  rf [16];
   logic [7:0]  mem [65536];

   int ack_delay = 0;
   bit ack_tie = 1'b0;
   int wait_cnt = 0;
   int hs_cnt = 0;
   int we_cnt = 0;
   int checks = 0;
   int errors = 0;

   bit          pend = 1'b0;
   logic [15:0] p_addr;
   logic [7:0]  p_wdata;
   logic        p_we;

   regfile_ctx_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .save_req  (save_req),
      .rest_req  (rest_req),
      .sp_in     (sp_in),
`ifdef CTX_MASK_EN
      .reg_mask  (reg_mask),
`endif
      .busy      (busy),
      .cpu_stall (cpu_stall),
      .done      (done),
      .sp_out    (sp_out),
      .rf_sel    (rf_sel),
      .rf_dout   (rf_dout),
      .rf_din    (rf_din),
      .rf_we     (rf_we),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   assign rf_dout   = rf[rf_sel];
   assign mem_rdata = mem[mem_addr];
   assign mem_ack   = ack_tie | (mem_req && (wait_cnt >= ack_delay));

   // Memory and register-file models.
   always @(posedge clk) begin
      if (mem_req && mem_ack) begin
         hs_cnt++;
         if (mem_we) mem[mem_addr] = mem_wdata;
         wait_cnt <= 0;
      end else if (mem_req) begin
         wait_cnt <= wait_cnt + 1;
      end else begin
         wait_cnt <= 0;
      end
      if (rf_we) begin
         rf[rf_sel] = rf_din;
         we_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bus-protocol monitor: request held and stable until ack, ports never shared.
   always @(negedge clk) begin
      if (!reset) begin
         pend = 1'b0;
      end else begin
         if (rf_we && mem_req) check("rf_we_with_mem_req", 1, 0);
         if (cpu_stall !== busy) check("stall_eq_busy", {31'd0, cpu_stall}, {31'd0, busy});
         if (pend) begin
            check("req_held", {31'd0, mem_req}, 1);
            check("req_stable", {7'd0, mem_we, mem_wdata, mem_addr}, {7'd0, p_we, p_wdata, p_addr});
         end
         pend    = mem_req && !mem_ack;
         p_addr  = mem_addr;
         p_wdata = mem_wdata;
         p_we    = mem_we;
      end
   end

   function automatic int popcnt(input logic [15:0] m);
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(m[i]);
      return n;
   endfunction

   function automatic logic [15:0] eff(input logic [15:0] m);
`ifdef CTX_MASK_EN
      return m;
`else
      return 16'hFFFF & (m | 16'hFFFF);
`endif
   endfunction

   // Each transferred register: one register-side cycle plus (delay+1) memory cycles;
   // each skipped register: one idle cycle; plus the DONE cycle.
   function automatic int model_busy(input logic [15:0] m, input int dly, input bit tie);
      int n = popcnt(eff(m));
      int d = tie ? 0 : dly;
      return n * (d + 2) + (16 - n) + 1;
   endfunction

   function automatic logic [15:0] model_sp(input bit is_save, input logic [15:0] sp, input logic [15:0] m);
      logic [15:0] n = 16'(popcnt(eff(m)));
      return is_save ? sp - n : sp + n;
   endfunction

   task automatic chk_zero(input string tag);
      check({tag, "_busy"},  {31'd0, busy}, 0);
      check({tag, "_stall"}, {31'd0, cpu_stall}, 0);
      check({tag, "_done"},  {31'd0, done}, 0);
      check({tag, "_spout"}, {16'd0, sp_out}, 0);
      check({tag, "_rfsel"}, {28'd0, rf_sel}, 0);
      check({tag, "_rfdin"}, {24'd0, rf_din}, 0);
      check({tag, "_rfwe"},  {31'd0, rf_we}, 0);
      check({tag, "_mreq"},  {31'd0, mem_req}, 0);
      check({tag, "_mwe"},   {31'd0, mem_we}, 0);
      check({tag, "_maddr"}, {16'd0, mem_addr}, 0);
      check({tag, "_mwdat"}, {24'd0, mem_wdata}, 0);
   endtask

   // op: 0 save, 1 restore, 2 both requests (save expected).
   task automatic run_op(input string name, input int op, input logic [15:0] sp,
                         input logic [15:0] mask, input int dly, input bit tie, input bit pulse,
                         input logic [15:0] exp_sp, input int exp_busy);
      logic [15:0] m = eff(mask);
      bit          is_save = (op != 1);
      logic [15:0] exp_addr [16];
      logic [7:0]  exp_data [16];
      logic [7:0]  exp_rf [16];
      int k = 0, bc = 0, dc = 0, cyc = 0, hs0, we0;
      logic [15:0] spd = '0;

      for (int i = 0; i < 16; i++) exp_rf[i] = rf[i];
      if (is_save) begin
         for (int i = 15; i >= 0; i--)
            if (m[i]) begin
               exp_addr[k] = sp - 16'(k + 1);
               exp_data[k] = rf[i];
               k++;
            end
      end else begin
         for (int i = 0; i < 16; i++)
            if (m[i]) begin
               exp_rf[i] = mem[sp + 16'(k)];
               k++;
            end
      end
      hs0 = hs_cnt;
      we0 = we_cnt;

      @(negedge clk);
      ack_delay = dly;
      ack_tie   = tie;
      reg_mask  = mask;
      sp_in     = sp;
      save_req  = (op != 1);
      rest_req  = (op != 0);
      @(negedge clk);
      save_req = 1'b0;
      rest_req = 1'b0;
      while (busy && cyc < 2000) begin
         bc++;
         if (done) begin
            dc++;
            spd = sp_out;
         end
         rest_req = pulse && (bc == 10);
         @(negedge clk);
         cyc++;
      end
      rest_req = 1'b0;
      check({name, "_timeout"}, {31'd0, cyc < 2000}, 1);
      check({name, "_busy_cycles"}, bc, exp_busy);
      check({name, "_done_pulses"}, dc, 1);
      check({name, "_sp_at_done"}, {16'd0, spd}, {16'd0, exp_sp});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (busy || done) check({name, "_spurious_busy"}, {30'd0, busy, done}, 0);
      end
      check({name, "_sp_held"}, {16'd0, sp_out}, {16'd0, exp_sp});
      check({name, "_mem_xfers"}, hs_cnt - hs0, k);
      check({name, "_rf_writes"}, we_cnt - we0, is_save ? 0 : k);
      if (is_save) begin
         for (int j = 0; j < k; j++)
            check({name, "_mem"}, {8'd0, exp_addr[j], mem[exp_addr[j]]}, {8'd0, exp_addr[j], exp_data[j]});
      end else begin
         for (int i = 0; i < 16; i++)
            check({name, "_rf"}, {20'd0, 4'(i), rf[i]}, {20'd0, 4'(i), exp_rf[i]});
      end
      ack_tie = 1'b0;
   endtask

   typedef struct {
      string       name;
      int          op;
      logic [15:0] sp;
      logic [15:0] mask;
      int          dly;
      bit          tie;
      bit          pulse;
      bit          init_a0;
      bit          clr_rf;
      bit          chk_a0;
      logic [15:0] exp_sp;
      int          exp_busy;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vecs.push_back('{"save_0100",   0, 16'h0100, 16'hFFFF, 0, 1, 0, 1, 0, 0, 16'h00F0, 33});
      vecs.push_back('{"rest_00F0",   1, 16'h00F0, 16'hFFFF, 2, 0, 0, 0, 1, 1, 16'h0100, 65});
      vecs.push_back('{"both_req",    2, 16'h0300, 16'hFFFF, 0, 1, 0, 0, 0, 0, 16'h02F0, 33});
      vecs.push_back('{"mid_pulse",   0, 16'h0400, 16'hFFFF, 1, 0, 1, 0, 0, 0, 16'h03F0, 49});
      vecs.push_back('{"wrap_save",   0, 16'h0000, 16'hFFFF, 0, 1, 0, 0, 0, 0, 16'hFFF0, 33});
      vecs.push_back('{"wrap_rest",   1, 16'hFFF8, 16'hFFFF, 0, 0, 0, 0, 1, 0, 16'h0008, 33});
`ifdef CTX_MASK_EN
      vecs.push_back('{"mask_save",   0, 16'h0200, 16'h8001, 0, 1, 0, 0, 0, 0, 16'h01FE, 19});
      vecs.push_back('{"mask_zero",   1, 16'h0500, 16'h0000, 0, 1, 0, 0, 0, 0, 16'h0500, 17});
`endif

      for (int i = 0; i < 16; i++) rf[i] = 8'h00;
      #1;
      chk_zero("in_reset");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_zero("after_reset");

      foreach (vecs[v]) begin
         if (vecs[v].init_a0) for (int i = 0; i < 16; i++) rf[i] = 8'hA0 + 8'(i);
         if (vecs[v].clr_rf)  for (int i = 0; i < 16; i++) rf[i] = 8'h00;
         run_op(vecs[v].name, vecs[v].op, vecs[v].sp, vecs[v].mask, vecs[v].dly,
                vecs[v].tie, vecs[v].pulse, vecs[v].exp_sp, vecs[v].exp_busy);
         if (vecs[v].chk_a0)
            for (int i = 0; i < 16; i++)
               check("rest_a0_value", {24'd0, rf[i]}, {24'd0, 8'hA0 + 8'(i)});
      end

      // Reset while a SAVE_WR is pending after five registers have been stored.
      begin
         int hs0, cyc;
         for (int i = 0; i < 16; i++) rf[i] = 8'h50 + 8'(i);
         hs0 = hs_cnt;
         ack_delay = 3;
         sp_in = 16'h0800;
         @(negedge clk);
         save_req = 1'b1;
         @(negedge clk);
         save_req = 1'b0;
         cyc = 0;
         while (!((hs_cnt - hs0) == 5 && mem_req && mem_we) && cyc < 500) begin
            @(negedge clk);
            cyc++;
         end
         check("rst_mid_reach", {31'd0, cyc < 500}, 1);
         reset = 1'b0;
         #1;
         chk_zero("rst_mid");
         @(negedge clk);
         @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         chk_zero("rst_release");
         for (int j = 0; j < 5; j++)
            check("rst_no_rollback", {24'd0, mem[16'h07FF - 16'(j)]}, {24'd0, 8'h5F - 8'(j)});
         run_op("save_after_rst", 0, 16'h0900, 16'hFFFF, 0, 1, 0, 16'h08F0, 33);
      end

      // Randomized transactions against the reference model.
      for (int t = 0; t < 20; t++) begin
         int          op  = int'($urandom_range(0, 1));
         logic [15:0] sp  = 16'($urandom);
         logic [15:0] msk = 16'($urandom);
         int          dly = int'($urandom_range(0, 3));
         for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
         if (op == 1) for (int i = 0; i < 16; i++) mem[sp + 16'(i)] = 8'($urandom);
         run_op("random", op, sp, msk, dly, 0, 0,
                model_sp(op == 0, sp, msk), model_busy(msk, dly, 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
